seq_div16x8: RTL and testbench
==============================

Name: seq_div16x8

Overview:
- Iterative restoring divider: 16-bit dividend / 8-bit divisor -> 16-bit quotient, 8-bit remainder.
- Inverse-direction companion to the team's 8x8 multiplier family (4x4 sub-multipliers plus adder tree). Recovers operands and normalises products in the same FPGA arithmetic datapaths.
- Valid/ready handshake on input and output.
- One quotient bit per clock, MSB first.

Parameters:
- APPROX_SKIP, 4: number of low quotient bits not computed when APPROX_DIV_EN is defined. Legal range 0..8. Ignored otherwise.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  block can accept operands
- dividend  input  16  unsigned dividend
- divisor  input  8  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- quot  output  16  unsigned quotient
- rem  output  8  unsigned remainder
- div_zero  output  1  divisor was zero for this result

Behaviour:
- Single clock domain clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - in_ready=1
  - out_valid=0, quot=0, rem=0, div_zero=0
  - state=IDLE, iteration counter=0
  - partial remainder=0
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, capture dividend, divisor, and NITER. NITER=16 (or 16-APPROX_SKIP, see Optional Feature).
  - If divisor==0: next state DONE with quot=16'hFFFF, rem=dividend[7:0], div_zero=1.
  - Otherwise: next state RUN, partial remainder R(9b)=0, div_zero=0.
- RUN:
  - in_ready=0. Each cycle, shift: R={R[7:0], next dividend bit (MSB first)}.
  - If R>=divisor: R=R-divisor and quotient bit=1. Else quotient bit=0.
  - R is 9 bits because the shifted value is < 2*divisor <= 510. R after subtraction is always < divisor and fits in 8 bits.
  - After NITER iterations: next state DONE, rem=R[7:0].
- DONE:
  - out_valid=1. quot, rem and div_zero are held stable while out_valid=1 and out_ready=0.
  - On out_ready: next state IDLE, out_valid=0.
  - in_ready returns the following cycle. No same-cycle accept in DONE.
- Latency, measured from the accepting edge to the first cycle with out_valid=1:
  - NITER edges for a non-zero divisor.
  - 1 edge for a zero divisor.
- Throughput: one operation per NITER+2 cycles when out_ready is held high.
- Input changes while in_ready=0 are ignored. Operands are registered at accept.
- rst during RUN or DONE: the result is discarded and the block returns to reset values on the next edge.
- rst simultaneous with an accept: reset wins and nothing is captured.
- Boundaries:
  - dividend=0 -> quot=0, rem=0.
  - divisor=1 -> quot=dividend, rem=0.
  - dividend<divisor -> quot=0, rem=dividend[7:0].

Optional Feature:
- Macro: APPROX_DIV_EN.
- Defined:
  - NITER=16-APPROX_SKIP. Only the top 16-APPROX_SKIP dividend bits are iterated.
  - quot = floor((dividend>>APPROX_SKIP)/divisor) << APPROX_SKIP. The low APPROX_SKIP quotient bits are 0.
  - rem = (dividend>>APPROX_SKIP) mod divisor.
  - Latency drops by APPROX_SKIP cycles.
  - Divide-by-zero handling is unchanged.
- Undefined: exact division, NITER=16, and APPROX_SKIP has no effect.

Test Plan:
- Exact result and latency: dividend=1000, divisor=7, out_ready=1 -> quot=142, rem=6, div_zero=0. out_valid rises exactly 16 edges after accept.
- Divide by zero: dividend=16'h1234, divisor=0 -> one edge later quot=16'hFFFF, rem=8'h34, div_zero=1.
- Maximum dividend: 16'hFFFF/1 -> quot=16'hFFFF, rem=0. Also 16'hFFFF/255 -> quot=257, rem=0.
- Backpressure: result 500/3 with out_ready=0 for 5 cycles -> quot=166, rem=2 held stable and in_ready=0 throughout. After out_ready, in_ready=1 the next cycle.
- Reset mid-run: rst asserted on the 8th RUN cycle -> next cycle all outputs at reset values, in_ready=1. A subsequent 100/10 gives quot=10, rem=0.
- APPROX_DIV_EN, APPROX_SKIP=4: 1000/7 -> quot=128, rem=6, latency 12 edges. 16'hFFFF/1 -> quot=16'hFFF0, rem=0.

Source files
------------

// File: rtl/seq_div16x8.sv
// seq_div16x8 - iterative restoring divider, 16-bit dividend / 8-bit divisor.
// Produces one quotient bit per clock, MSB first, behind valid/ready handshakes
// on the operand and result sides.
// Optional build macro: APPROX_DIV_EN - when defined, the low APPROX_SKIP
// quotient bits are not computed. The result is forced to zero in those bits,
// and the latency shrinks by APPROX_SKIP cycles.

module seq_div16x8 #(
    parameter int APPROX_SKIP = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quot,
    output logic [7:0]  rem,
    output logic        div_zero
);

`ifdef APPROX_DIV_EN
    localparam bit APPROX_EN = 1'b1;
`else
    localparam bit APPROX_EN = 1'b0;
`endif

    // Out-of-range skip values are clamped to 0..8, so that at least 8 dividend bits are iterated.
    localparam int SKIP_CLAMP = (APPROX_SKIP < 0) ? 0 : ((APPROX_SKIP > 8) ? 8 : APPROX_SKIP);
    localparam int SKIP       = APPROX_EN ? SKIP_CLAMP : 0;
    localparam int NITER      = 16 - SKIP;
    localparam logic [4:0] LAST_ITER = 5'(NITER - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    // dvd_q is one shift register for both operands. Dividend bits leave at the
    // top, and quotient bits enter at the bottom.
    logic [15:0] dvd_q;
    logic [7:0]  dvs_q;
    // The partial remainder is always below the divisor between iterations, so
    // 8 stored bits are enough. The 9th bit exists only in the shifted value.
    logic [7:0]  r_q;

    logic        in_ready_q;
    logic        out_valid_q;
    logic [15:0] quot_q;
    logic [7:0]  rem_q;
    logic        div_zero_q;

    logic [8:0]  r_shift;
    logic        q_bit;
    logic [7:0]  r_d;
    logic [15:0] dvd_d;

    // One restoring step: shift in the next dividend bit, then subtract the divisor if it fits.
    always_comb begin
        // NOTE: every combinational output is given a default first, so no path leaves it unassigned and no latch is inferred.
        r_shift = 9'd0;
        q_bit   = 1'b0;
        r_d     = 8'd0;
        dvd_d   = 16'd0;

        r_shift = {r_q, dvd_q[15]};
        q_bit   = (r_shift >= {1'b0, dvs_q});
        // When the subtraction happens, the true difference is below the divisor, so the low 8 bits are exact.
        r_d     = q_bit ? (r_shift[7:0] - dvs_q) : r_shift[7:0];
        dvd_d   = {dvd_q[14:0], q_bit};
    end

    // Control FSM, datapath registers and registered handshake/result outputs.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments, so every register samples pre-edge values.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 5'd0;
            dvd_q       <= 16'd0;
            dvs_q       <= 8'd0;
            r_q         <= 8'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quot_q      <= 16'd0;
            rem_q       <= 8'd0;
            div_zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        dvd_q      <= dividend;
                        dvs_q      <= divisor;
                        cnt_q      <= 5'd0;
                        r_q        <= 8'd0;
                        if (divisor == 8'd0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quot_q      <= 16'hFFFF;
                            rem_q       <= dividend[7:0];
                            div_zero_q  <= 1'b1;
                        end else begin
                            state_q    <= RUN;
                            div_zero_q <= 1'b0;
                        end
                    end
                end

                RUN: begin
                    dvd_q <= dvd_d;
                    r_q   <= r_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == LAST_ITER) begin
                        state_q     <= DONE;
                        cnt_q       <= 5'd0;
                        out_valid_q <= 1'b1;
                        // After NITER shifts, the quotient sits in the low NITER bits. Move it up over the skipped positions.
                        quot_q      <= dvd_d << SKIP;
                        rem_q       <= r_d;
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end

                default: begin
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign quot      = quot_q;
    assign rem       = rem_q;
    assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_div16x8.sv
// Directed testbench for seq_div16x8. Expected values are hand-computed.
// It builds with or without APPROX_DIV_EN, using APPROX_SKIP = 4.

module tb_seq_div16x8;

`ifdef APPROX_DIV_EN
    localparam int NITER = 12;
`else
    localparam int NITER = 16;
`endif

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quot;
    logic [7:0]  rem;
    logic        div_zero;

    int n_tests = 0;
    int n_fail  = 0;

    seq_div16x8 #(
        .APPROX_SKIP(4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .dividend  (dividend),
        .divisor   (divisor),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quot      (quot),
        .rem       (rem),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle 1 ns past it before driving or sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand pair, take the accepting edge, then count the edges until out_valid.
    task automatic run_op(input logic [15:0] a, input logic [7:0] b, output int lat);
        in_valid = 1'b1;
        dividend = a;
        divisor  = b;
        step();
        in_valid = 1'b0;
        dividend = ~a;
        divisor  = ~b;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++; if (quot !== 16'd0) begin n_fail++; $display("FAIL reset_quot: got %0d expected 0", quot); end
        n_tests++; if (rem !== 8'd0) begin n_fail++; $display("FAIL reset_rem: got %0d expected 0", rem); end
        n_tests++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL reset_div_zero: got %b expected 0", div_zero); end
        rst = 1'b0;
        step();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_exact();
        int lat;
        logic [15:0] eq;
        logic [7:0]  er;
`ifdef APPROX_DIV_EN
        eq = 16'd128; er = 8'd6;
`else
        eq = 16'd142; er = 8'd6;
`endif
        out_ready = 1'b1;
        run_op(16'd1000, 8'd7, lat);
        n_tests++; if (lat != NITER) begin n_fail++; $display("FAIL exact_latency: got %0d edges expected %0d", lat, NITER); end
        n_tests++; if (quot !== eq) begin n_fail++; $display("FAIL exact_quot: got %0d expected %0d", quot, eq); end
        n_tests++; if (rem !== er) begin n_fail++; $display("FAIL exact_rem: got %0d expected %0d", rem, er); end
        n_tests++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL exact_div_zero: got %b expected 0", div_zero); end
        step();
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL exact_return_idle: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_div_zero();
        int lat;
        out_ready = 1'b0;
        run_op(16'h1234, 8'd0, lat);
        n_tests++; if (lat != 0) begin n_fail++; $display("FAIL divzero_latency: got %0d extra edges expected 0", lat); end
        n_tests++; if (quot !== 16'hFFFF) begin n_fail++; $display("FAIL divzero_quot: got %h expected ffff", quot); end
        n_tests++; if (rem !== 8'h34) begin n_fail++; $display("FAIL divzero_rem: got %h expected 34", rem); end
        n_tests++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL divzero_flag: got %b expected 1", div_zero); end
        step();
        n_tests++; if (out_valid !== 1'b1 || quot !== 16'hFFFF || div_zero !== 1'b1) begin n_fail++; $display("FAIL divzero_hold: out_valid=%b quot=%h div_zero=%b", out_valid, quot, div_zero); end
        out_ready = 1'b1;
        step();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL divzero_drain: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_max();
        int lat;
        logic [15:0] eq1, eq2;
        logic [7:0]  er2;
`ifdef APPROX_DIV_EN
        eq1 = 16'hFFF0; eq2 = 16'd256; er2 = 8'd15;
`else
        eq1 = 16'hFFFF; eq2 = 16'd257; er2 = 8'd0;
`endif
        out_ready = 1'b1;
        run_op(16'hFFFF, 8'd1, lat);
        n_tests++; if (quot !== eq1 || rem !== 8'd0) begin n_fail++; $display("FAIL max_div1: got quot=%h rem=%0d expected quot=%h rem=0", quot, rem, eq1); end
        step();
        run_op(16'hFFFF, 8'd255, lat);
        n_tests++; if (quot !== eq2 || rem !== er2) begin n_fail++; $display("FAIL max_div255: got quot=%0d rem=%0d expected quot=%0d rem=%0d", quot, rem, eq2, er2); end
        step();
    endtask

    task automatic test_boundaries();
        int lat;
        logic [15:0] eq3;
        logic [7:0]  er2;
`ifdef APPROX_DIV_EN
        er2 = 8'd12; eq3 = 16'h1230;
`else
        er2 = 8'd200; eq3 = 16'h1234;
`endif
        out_ready = 1'b1;
        run_op(16'd0, 8'd5, lat);
        n_tests++; if (quot !== 16'd0 || rem !== 8'd0) begin n_fail++; $display("FAIL bnd_zero_dividend: got quot=%0d rem=%0d expected 0/0", quot, rem); end
        step();
        run_op(16'd200, 8'd250, lat);
        n_tests++; if (quot !== 16'd0 || rem !== er2) begin n_fail++; $display("FAIL bnd_small_dividend: got quot=%0d rem=%0d expected 0/%0d", quot, rem, er2); end
        step();
        run_op(16'h1234, 8'd1, lat);
        n_tests++; if (quot !== eq3 || rem !== 8'd0) begin n_fail++; $display("FAIL bnd_div1: got quot=%h rem=%0d expected %h/0", quot, rem, eq3); end
        step();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] eq;
        logic [7:0]  er;
        logic        busy_ok;
`ifdef APPROX_DIV_EN
        eq = 16'd160; er = 8'd1;
`else
        eq = 16'd166; er = 8'd2;
`endif
        out_ready = 1'b0;
        in_valid  = 1'b1;
        dividend  = 16'd500;
        divisor   = 8'd3;
        step();
        // Keep offering a different operand pair while the divider is busy. It must stay ignored.
        dividend = 16'd999;
        divisor  = 8'd9;
        busy_ok  = 1'b1;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            step();
            lat++;
        end
        n_tests++; if (busy_ok !== 1'b1) begin n_fail++; $display("FAIL bp_in_ready_run: in_ready was high while busy"); end
        n_tests++; if (quot !== eq || rem !== er) begin n_fail++; $display("FAIL bp_result: got quot=%0d rem=%0d expected %0d/%0d", quot, rem, eq, er); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || quot !== eq || rem !== er) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: out_valid=%b in_ready=%b quot=%0d rem=%0d expected 1/0/%0d/%0d", i, out_valid, in_ready, quot, rem, eq, er);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
    endtask

    task automatic test_reset_mid_run();
        int lat;
        int seen;
        logic [7:0] er;
        logic [15:0] eq;
`ifdef APPROX_DIV_EN
        eq = 16'd0; er = 8'd6;
`else
        eq = 16'd10; er = 8'd0;
`endif
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 16'd1000;
        divisor   = 8'd7;
        step();
        in_valid = 1'b0;
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_run_handshake: in_ready=%b out_valid=%b expected 1/0", in_ready, out_valid); end
        n_tests++; if (quot !== 16'd0 || rem !== 8'd0 || div_zero !== 1'b0) begin n_fail++; $display("FAIL rst_run_outputs: quot=%0d rem=%0d div_zero=%b expected 0/0/0", quot, rem, div_zero); end
        seen = 0;
        repeat (20) begin
            step();
            if (out_valid === 1'b1) seen++;
        end
        n_tests++; if (seen != 0) begin n_fail++; $display("FAIL rst_run_discard: out_valid high %0d cycles expected 0", seen); end
        run_op(16'd100, 8'd10, lat);
        n_tests++; if (quot !== eq || rem !== er || lat != NITER) begin n_fail++; $display("FAIL rst_run_next_op: got quot=%0d rem=%0d lat=%0d expected %0d/%0d/%0d", quot, rem, lat, eq, er, NITER); end
        step();
    endtask

    task automatic test_reset_vs_accept();
        rst      = 1'b1;
        in_valid = 1'b1;
        dividend = 16'h0055;
        divisor  = 8'd0;
        step();
        rst      = 1'b0;
        in_valid = 1'b0;
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || div_zero !== 1'b0) begin n_fail++; $display("FAIL rst_accept_edge: out_valid=%b in_ready=%b div_zero=%b expected 0/1/0", out_valid, in_ready, div_zero); end
        step();
        n_tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_accept_nocapture: out_valid=%b in_ready=%b expected 0/1", out_valid, in_ready); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        int lat;
        logic [15:0] q1;
        logic [15:0] eq1, eq2;
        logic [7:0]  er2;
`ifdef APPROX_DIV_EN
        eq1 = 16'd128; eq2 = 16'd96; er2 = 8'd24;
`else
        eq1 = 16'd142; eq2 = 16'd101; er2 = 8'd0;
`endif
        out_ready = 1'b1;
        in_valid  = 1'b1;
        dividend  = 16'd1000;
        divisor   = 8'd7;
        step();
        // Leave in_valid high with the second operand pair. It is taken as soon as in_ready returns.
        dividend = 16'd7777;
        divisor  = 8'd77;
        q1  = 16'd0;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
            if (out_valid === 1'b1) q1 = quot;
        end
        n_tests++; if (cyc != NITER + 1) begin n_fail++; $display("FAIL b2b_period: in_ready back after %0d edges expected %0d", cyc, NITER + 1); end
        n_tests++; if (q1 !== eq1) begin n_fail++; $display("FAIL b2b_first_quot: got %0d expected %0d", q1, eq1); end
        step();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            step();
            lat++;
        end
        n_tests++; if (quot !== eq2 || rem !== er2 || lat != NITER) begin n_fail++; $display("FAIL b2b_second: got quot=%0d rem=%0d lat=%0d expected %0d/%0d/%0d", quot, rem, lat, eq2, er2, NITER); end
        step();
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = 16'd0;
        divisor   = 8'd0;
        test_reset();
        test_exact();
        test_div_zero();
        test_max();
        test_boundaries();
        test_backpressure();
        test_reset_mid_run();
        test_reset_vs_accept();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
